bmu_issue_arbiter: RTL and testbench
====================================

Name: bmu_issue_arbiter

Overview:
- Shares one BMU datapath between NUM_REQ issue requesters.
- Round-robin arbitration with a valid/ready handshake per requester; at most one op issued per cycle.
- Tracks each issued op through a fixed-latency tag pipeline and returns resultFf/error to the originating requester.
- Sits between the issue stage and the BMU. Its BMU-side outputs drive validIn, ap, aIn, bIn, csrRenIn and csrRdataIn.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BMU_LATENCY, 1, cycles from validIn sampled to resultFf/error valid (1..4).
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- reqValid  in  NUM_REQ  per-requester op valid.
- reqReady  out  NUM_REQ  per-requester grant; op accepted when valid&ready.
- reqAp  in  NUM_REQ x rtl_alu_pkt_t  per-requester op packet.
- reqA  in  NUM_REQ x 32  operand A.
- reqB  in  NUM_REQ x 32  operand B.
- reqCsrRen  in  NUM_REQ  CSR read enable.
- reqCsrRdata  in  NUM_REQ x 32  CSR read data.
- flush  in  1  kill all in-flight ops and block issue this cycle.
- bmuValidIn  out  1  to BMU validIn.
- bmuAp  out  rtl_alu_pkt_t  to BMU ap.
- bmuAIn  out  32  to BMU aIn.
- bmuBIn  out  32  to BMU bIn.
- bmuCsrRenIn  out  1  to BMU csrRenIn.
- bmuCsrRdataIn  out  32  to BMU csrRdataIn.
- bmuResultFf  in  32  from BMU resultFf.
- bmuError  in  1  from BMU error.
- rspValid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- rspResult  out  32  response result, shared by all requesters.
- rspError  out  1  response error flag.
- busy  out  1  any op in flight.
- errCount  out  ERR_CNT_W  saturating count of responses with error=1.

Behaviour:
- Reset (rst=1 at posedge):
  - rrPtr=0, all tag-pipeline entries invalid, errCount=0.
  - While rst is high: reqReady=0, bmuValidIn=0, rspValid=0, busy=0.
  - In-flight ops at reset are discarded; no response is ever produced for them.
- Arbitration (combinational, same cycle):
  - Search reqValid starting at index rrPtr, wrapping modulo NUM_REQ; the first set bit wins.
  - grant is one-hot or zero, and reqReady=grant.
  - No grant when flush=1 or rst=1.
- Issue:
  - bmuValidIn=|grant.
  - bmu* data outputs = AND-OR mux of the granted requester's fields; all zero when no grant.
  - Handshake rule: a requester holding reqValid=1 keeps its fields stable until reqReady=1. The arbiter neither checks nor relies on this beyond one cycle.
- Pointer: on a grant to requester i, rrPtr <= (i+1) mod NUM_REQ. Without a grant, rrPtr holds.
- Tag pipeline:
  - BMU_LATENCY stages of {v, id}.
  - Stage 0 is loaded with {|grant, encode(grant)}; stages shift every cycle.
  - At the last stage with v=1: rspValid[id]=1, rspResult=bmuResultFf, rspError=bmuError.
  - Otherwise rspValid=0 and rspResult/rspError=0.
- Flush:
  - Clears v in all stages at the posedge.
  - The response that would appear in the flush cycle is suppressed (rspValid=0).
  - No grant in the flush cycle.
- busy = OR of all stage v bits, combined with bmuValidIn.
- errCount increments on each delivered response with rspError=1 and saturates at all-ones. Suppressed responses are not counted.
- Back-to-back issue every cycle is supported. There is no response back-pressure; requesters must accept rspValid.
- Simultaneous events:
  - Issue and response in the same cycle are independent.
  - flush together with reqValid gives no grant and no rrPtr change.

Decomposition:
- Shared package bmu_arb_pkg holds:
  - the req-id type (clog2 NUM_REQ bits);
  - the tag struct {v, id};
  - the ERR_CNT default;
  - the import of rtl_alu_pkt_t.
- Sub-module rr_arbiter (NUM_REQ, rrPtr in, req in, grant out, combinational) is instantiated once.
- Tag pipeline and counter live in the top.

Test Plan:
- Reset then idle -> reqReady=0, bmuValidIn=0, rspValid=0, errCount=0, busy=0.
- Req0 only, aIn=0x0000_00F0, bIn=0x4, LATENCY=1 -> reqReady[0]=1 in cycle N; bmuAIn=0xF0; rspValid[0]=1 in N+1 with rspResult=bmuResultFf.
- Both requesters valid for 4 cycles from reset -> grants 0,1,0,1; responses return tagged 0,1,0,1 in order.
- Issue in cycle N, flush in N+1 (LATENCY=2) -> no rspValid in N+2; busy=0 in N+2; no grant in N+1.
- Three responses with bmuError=1 -> errCount=3; preset errCount near saturation, one more error -> errCount=0xFFFF and held.
- rst asserted one cycle after an issue -> no response ever appears; rrPtr=0, so the next simultaneous request grants 0.

Source files
------------

// File: rtl/bmu_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bmu_arb_pkg : shared types for the BMU issue arbiter                |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package bmu_arb_pkg;

  localparam int MAX_REQ       = 4;
  localparam int REQ_ID_W      = 2;
  localparam int ERR_CNT_W_DEF = 16;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } tag_t;

  // Decoded BMU op packet as presented to the BMU ap input.
  typedef struct packed {
    logic valid;
    logic land;
    logic lor;
    logic lxor;
    logic sll;
    logic srl;
    logic sra;
    logic ror;
    logic rol;
    logic clz;
    logic ctz;
    logic cpop;
    logic minv;
    logic maxv;
    logic sh1add;
    logic bext;
  } rtl_alu_pkt_t;

endpackage
`default_nettype wire

// File: rtl/bmu_issue_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant starting at ptr        |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_arbiter
  import bmu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   pos;

  // All selects use loop constants; pos only steers which constant index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (pos == i) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmu_issue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bmu_issue_arbiter : round-robin sharing of one BMU with tag return  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bmu_issue_arbiter
  import bmu_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BMU_LATENCY = 1,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            reqValid,
  output logic [NUM_REQ-1:0]            reqReady,
  input  rtl_alu_pkt_t [NUM_REQ-1:0]    reqAp,
  input  logic [NUM_REQ-1:0][31:0]      reqA,
  input  logic [NUM_REQ-1:0][31:0]      reqB,
  input  logic [NUM_REQ-1:0]            reqCsrRen,
  input  logic [NUM_REQ-1:0][31:0]      reqCsrRdata,
  input  logic                          flush,
  output logic                          bmuValidIn,
  output rtl_alu_pkt_t                  bmuAp,
  output logic [31:0]                   bmuAIn,
  output logic [31:0]                   bmuBIn,
  output logic                          bmuCsrRenIn,
  output logic [31:0]                   bmuCsrRdataIn,
  input  logic [31:0]                   bmuResultFf,
  input  logic                          bmuError,
  output logic [NUM_REQ-1:0]            rspValid,
  output logic [31:0]                   rspResult,
  output logic                          rspError,
  output logic                          busy,
  output logic [ERR_CNT_W-1:0]          errCount
);

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_id;
  req_id_t            rr_ptr;
  tag_t               pipe [BMU_LATENCY];
  tag_t               last;
  logic               deliver;
  logic               any_v;

  assign req_masked = reqValid & {NUM_REQ{~(flush | rst)}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req   (req_masked),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign reqReady   = grant;
  assign bmuValidIn = |grant;

  always_comb begin
    bmuAp         = '0;
    bmuAIn        = '0;
    bmuBIn        = '0;
    bmuCsrRenIn   = 1'b0;
    bmuCsrRdataIn = '0;
    grant_id      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bmuAp         = bmuAp | (reqAp[i] & {$bits(rtl_alu_pkt_t){grant[i]}});
      bmuAIn        = bmuAIn | (reqA[i] & {32{grant[i]}});
      bmuBIn        = bmuBIn | (reqB[i] & {32{grant[i]}});
      bmuCsrRenIn   = bmuCsrRenIn | (reqCsrRen[i] & grant[i]);
      bmuCsrRdataIn = bmuCsrRdataIn | (reqCsrRdata[i] & {32{grant[i]}});
      if (grant[i]) grant_id = req_id_t'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (grant_id == req_id_t'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Flush and reset both kill every in-flight tag at this edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < BMU_LATENCY; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{v: |grant, id: grant_id};
      for (int k = 1; k < BMU_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign last    = pipe[BMU_LATENCY-1];
  assign deliver = last.v & ~flush & ~rst;

  always_comb begin
    any_v = 1'b0;
    for (int k = 0; k < BMU_LATENCY; k++) any_v = any_v | pipe[k].v;
  end

  assign busy = ~rst & (any_v | bmuValidIn);

  always_comb begin
    rspValid = '0;
    for (int i = 0; i < NUM_REQ; i++) rspValid[i] = deliver && (last.id == req_id_t'(i));
  end

  assign rspResult = deliver ? bmuResultFf : '0;
  assign rspError  = deliver & bmuError;

  always_ff @(posedge clk) begin
    if (rst) begin
      errCount <= '0;
    end else if (deliver && bmuError && (errCount != {ERR_CNT_W{1'b1}})) begin
      errCount <= errCount + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmu_issue_arbiter.sv
`default_nettype none
// Scoreboard bench: two arbiters (latency 1 / 16-bit counter, latency 2 / 2-bit counter)
// share one directed stimulus table; expected responses are queued at issue time.
module tb_bmu_issue_arbiter;
  import bmu_arb_pkg::*;

  localparam int NROWS = 30;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [1:0] valid;
    logic       err;
    logic [1:0] gnt;
  } row_t;

  typedef struct packed {
    logic [31:0] due;
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  logic [1:0] reqValid;
  rtl_alu_pkt_t [1:0] reqAp;
  logic [1:0][31:0] reqA;
  logic [1:0][31:0] reqB;
  logic [1:0] reqCsrRen;
  logic [1:0][31:0] reqCsrRdata;
  logic [31:0] bmuResultFf;
  logic bmuError;

  logic [1:0] readyA, readyB, rspValidA, rspValidB;
  logic validInA, validInB, csrRenA, csrRenB, rspErrorA, rspErrorB, busyA, busyB;
  rtl_alu_pkt_t apA, apB;
  logic [31:0] aInA, aInB, bInA, bInB, csrRdA, csrRdB, rspResultA, rspResultB;
  logic [15:0] errCountA;
  logic [1:0]  errCountB;

  bmu_issue_arbiter #(.NUM_REQ(2), .BMU_LATENCY(1), .ERR_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(readyA), .reqAp(reqAp),
    .reqA(reqA), .reqB(reqB), .reqCsrRen(reqCsrRen), .reqCsrRdata(reqCsrRdata),
    .flush(flush), .bmuValidIn(validInA), .bmuAp(apA), .bmuAIn(aInA), .bmuBIn(bInA),
    .bmuCsrRenIn(csrRenA), .bmuCsrRdataIn(csrRdA), .bmuResultFf(bmuResultFf),
    .bmuError(bmuError), .rspValid(rspValidA), .rspResult(rspResultA),
    .rspError(rspErrorA), .busy(busyA), .errCount(errCountA));

  bmu_issue_arbiter #(.NUM_REQ(2), .BMU_LATENCY(2), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(readyB), .reqAp(reqAp),
    .reqA(reqA), .reqB(reqB), .reqCsrRen(reqCsrRen), .reqCsrRdata(reqCsrRdata),
    .flush(flush), .bmuValidIn(validInB), .bmuAp(apB), .bmuAIn(aInB), .bmuBIn(bInB),
    .bmuCsrRenIn(csrRenB), .bmuCsrRdataIn(csrRdB), .bmuResultFf(bmuResultFf),
    .bmuError(bmuError), .rspValid(rspValidB), .rspResult(rspResultB),
    .rspError(rspErrorB), .busy(busyB), .errCount(errCountB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  row_t rows [NROWS];
  exp_t qA[$];
  exp_t qB[$];
  exp_t ea, eb;
  int   cyc;
  int   n_checks;
  int   n_errors;
  logic mon_en;
  logic [15:0] cntA;
  logic [1:0]  cntB;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] res_of(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction
  function automatic logic [31:0] a_of(input int i, input int k);
    return (i == 0) ? 32'h0000_00F0 : (32'h1111_0000 | 32'(k));
  endfunction
  function automatic logic [31:0] b_of(input int i, input int k);
    return (i == 0) ? 32'h0000_0004 : (32'h2222_0000 | 32'(k));
  endfunction
  function automatic logic ren_of(input int i, input int k);
    return 1'((i + k) & 1);
  endfunction
  function automatic logic [31:0] rd_of(input int i, input int k);
    return 32'hC500_0000 | 32'(i << 12) | 32'(k);
  endfunction
  function automatic logic [15:0] ap_of(input int i, input int k);
    return 16'h8001 ^ 16'(k << 1) ^ 16'(i << 8);
  endfunction

  // Tag is still alive at cycle k if issued at k-1-j with no flush/rst edge in between.
  function automatic logic busy_exp(input int k, input int lat);
    logic clr;
    if (rows[k].rst) return 1'b0;
    if (rows[k].gnt != 2'b00) return 1'b1;
    for (int j = 0; j < lat; j++) begin
      if (k - 1 - j >= 0 && rows[k-1-j].gnt != 2'b00) begin
        clr = 1'b0;
        for (int m = k - j; m <= k - 1; m++) if (rows[m].rst || rows[m].flush) clr = 1'b1;
        if (!clr) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic set_row(input int k, input logic r, input logic f, input logic [1:0] v,
                         input logic e, input logic [1:0] g);
    rows[k] = '{rst: r, flush: f, valid: v, err: e, gnt: g};
  endtask

  task automatic apply(input int k);
    rst         = rows[k].rst;
    flush       = rows[k].flush;
    reqValid    = rows[k].valid;
    bmuError    = rows[k].err;
    bmuResultFf = res_of(k);
    for (int i = 0; i < 2; i++) begin
      reqA[i]        = a_of(i, k);
      reqB[i]        = b_of(i, k);
      reqCsrRen[i]   = ren_of(i, k);
      reqCsrRdata[i] = rd_of(i, k);
      reqAp[i]       = rtl_alu_pkt_t'(ap_of(i, k));
    end
  endtask

  task automatic check_issue(input int k);
    int id;
    logic [1:0] g;
    g  = rows[k].gnt;
    id = g[1] ? 1 : 0;
    chk("A_reqReady", 32'(readyA), 32'(g));
    chk("B_reqReady", 32'(readyB), 32'(g));
    chk("A_bmuValidIn", 32'(validInA), 32'(|g));
    chk("A_bmuAIn", aInA, (g != 0) ? a_of(id, k) : 32'h0);
    chk("A_bmuBIn", bInA, (g != 0) ? b_of(id, k) : 32'h0);
    chk("A_bmuCsrRenIn", 32'(csrRenA), (g != 0) ? 32'(ren_of(id, k)) : 32'h0);
    chk("A_bmuCsrRdataIn", csrRdA, (g != 0) ? rd_of(id, k) : 32'h0);
    chk("A_bmuAp", 32'(apA), (g != 0) ? 32'(ap_of(id, k)) : 32'h0);
    chk("B_bmuAIn", aInB, (g != 0) ? a_of(id, k) : 32'h0);
    chk("A_busy", 32'(busyA), 32'(busy_exp(k, 1)));
    chk("B_busy", 32'(busyB), 32'(busy_exp(k, 2)));
  endtask

  task automatic push(input int k);
    int   due;
    logic supp;
    logic [1:0] id;
    if (rows[k].gnt != 2'b00) begin
      id = rows[k].gnt[1] ? 2'd1 : 2'd0;
      for (int lat = 1; lat <= 2; lat++) begin
        due  = k + lat;
        supp = 1'b0;
        for (int m = k + 1; m <= due; m++) if (rows[m].rst || rows[m].flush) supp = 1'b1;
        if (!supp) begin
          if (lat == 1) qA.push_back('{due: 32'(due), id: id, res: res_of(due), err: rows[due].err});
          else          qB.push_back('{due: 32'(due), id: id, res: res_of(due), err: rows[due].err});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("A_errCount", 32'(errCountA), 32'(cntA));
      if (rspValidA != 2'b00) begin
        if (qA.size() == 0) begin
          fail_now("A_unexpected_rsp", 32'(rspValidA), 32'h0);
        end else begin
          ea = qA.pop_front();
          chk("A_rsp_cycle", 32'(cyc), ea.due);
          chk("A_rspValid", 32'(rspValidA), 32'(2'b01 << ea.id));
          chk("A_rspResult", rspResultA, ea.res);
          chk("A_rspError", 32'(rspErrorA), 32'(ea.err));
          if (ea.err && cntA != 16'hFFFF) cntA = cntA + 16'd1;
        end
      end else begin
        chk("A_idle_rspResult", rspResultA, 32'h0);
        if (qA.size() > 0 && qA[0].due <= 32'(cyc)) begin
          fail_now("A_missing_rsp", 32'h0, qA[0].due);
          void'(qA.pop_front());
        end
      end
      if (rst) cntA = '0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("B_errCount", 32'(errCountB), 32'(cntB));
      if (rspValidB != 2'b00) begin
        if (qB.size() == 0) begin
          fail_now("B_unexpected_rsp", 32'(rspValidB), 32'h0);
        end else begin
          eb = qB.pop_front();
          chk("B_rsp_cycle", 32'(cyc), eb.due);
          chk("B_rspValid", 32'(rspValidB), 32'(2'b01 << eb.id));
          chk("B_rspResult", rspResultB, eb.res);
          chk("B_rspError", 32'(rspErrorB), 32'(eb.err));
          if (eb.err && cntB != 2'b11) cntB = cntB + 2'd1;
        end
      end else begin
        chk("B_idle_rspError", 32'(rspErrorB), 32'h0);
        if (qB.size() > 0 && qB[0].due <= 32'(cyc)) begin
          fail_now("B_missing_rsp", 32'h0, qB[0].due);
          void'(qB.pop_front());
        end
      end
      if (rst) cntB = '0;
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    cntA     = '0;
    cntB     = '0;
    for (int k = 0; k < NROWS; k++) set_row(k, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    //        k   rst   flush valid  err   grant
    set_row(0,  1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    set_row(1,  1'b1, 1'b0, 2'b11, 1'b0, 2'b00);
    set_row(3,  1'b0, 1'b0, 2'b11, 1'b0, 2'b01);
    set_row(4,  1'b0, 1'b0, 2'b11, 1'b1, 2'b10);
    set_row(5,  1'b0, 1'b0, 2'b11, 1'b1, 2'b01);
    set_row(6,  1'b0, 1'b0, 2'b11, 1'b1, 2'b10);
    set_row(9,  1'b0, 1'b0, 2'b01, 1'b0, 2'b01);
    set_row(12, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10);
    set_row(13, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10);
    set_row(14, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00);
    set_row(15, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00);
    set_row(17, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01);
    set_row(18, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00);
    set_row(20, 1'b0, 1'b0, 2'b11, 1'b0, 2'b10);
    set_row(23, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01);
    set_row(24, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00);
    set_row(25, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01);
    set_row(26, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00);
    set_row(27, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00);

    cyc = 0;
    apply(0);
    #2;
    check_issue(0);
    for (int k = 1; k < NROWS; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      apply(k);
      mon_en = 1'b1;
      #1;
      check_issue(k);
      push(k);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("A_queue_drained", 32'(qA.size()), 32'h0);
    chk("B_queue_drained", 32'(qB.size()), 32'h0);
    chk("A_final_errCount", 32'(errCountA), 32'h1);
    chk("B_final_errCount", 32'(errCountB), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
